// File: rtl/layer_compositor.sv
// Two-stage priority compositor: merges NUM_LAYERS keyed/enabled layers over a background
// into one RGB332 pixel, expands it to 24-bit colour and reports collider overlaps per pixel and per frame.
module layer_compositor #(
    parameter int           NUM_LAYERS      = 10,
    parameter logic [7:0]   TRANSPARENT_KEY = 8'hFF,
    parameter bit           KEY_EN          = 1'b1,
    parameter int           COLLIDER_LAYER  = 0
) (
    input  logic                      clk,
    input  logic                      resetN,
    input  logic [NUM_LAYERS-1:0]     layerEnable,
    input  logic [NUM_LAYERS-1:0]     drawReq,
    input  logic [8*NUM_LAYERS-1:0]   layerRGB,
    input  logic [7:0]                backGroundRGB,
    input  logic                      pxlValid,
    input  logic                      startOfFrame,
    output logic [7:0]                redOut,
    output logic [7:0]                greenOut,
    output logic [7:0]                blueOut,
    output logic                      pxlValidOut,
    output logic [4:0]                winLayer,
    output logic [NUM_LAYERS-1:0]     collisionNow,
    output logic [NUM_LAYERS-1:0]     frameCollision,
    output logic                      frameCollisionValid
);

    localparam logic [4:0] WIN_BLANK = 5'd31;
    localparam logic [4:0] WIN_BG    = 5'(NUM_LAYERS);
    localparam logic [NUM_LAYERS-1:0] COLLIDER_MASK =
        {{(NUM_LAYERS-1){1'b0}}, 1'b1} << COLLIDER_LAYER;

    logic [NUM_LAYERS-1:0]   hit_next;

    logic [NUM_LAYERS-1:0]   hit_s1_reg;
    logic [8*NUM_LAYERS-1:0] rgb_s1_reg;
    logic [7:0]              bg_s1_reg;
    logic                    valid_s1_reg;
    logic                    sof_s1_reg;

    logic [7:0]              tmp_rgb_next;
    logic [4:0]              win_next;
    logic [NUM_LAYERS-1:0]   collision_next;

    logic [7:0]              tmp_rgb_reg;
    logic [4:0]              win_reg;
    logic                    valid_s2_reg;
    logic [NUM_LAYERS-1:0]   collision_reg;
    logic [NUM_LAYERS-1:0]   acc_reg;
    logic [NUM_LAYERS-1:0]   frame_coll_reg;
    logic                    frame_valid_reg;

    // A keyed pixel counts as "not drawn" so lower layers show through it.
    generate
        for (genvar gi = 0; gi < NUM_LAYERS; gi++) begin : g_hit
            assign hit_next[gi] = drawReq[gi] & layerEnable[gi] &
                                  (!KEY_EN || (layerRGB[8*gi +: 8] != TRANSPARENT_KEY));
        end
    endgenerate

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            hit_s1_reg   <= '0;
            rgb_s1_reg   <= '0;
            bg_s1_reg    <= '0;
            valid_s1_reg <= 1'b0;
            sof_s1_reg   <= 1'b0;
        end else begin
            hit_s1_reg   <= hit_next;
            rgb_s1_reg   <= layerRGB;
            bg_s1_reg    <= backGroundRGB;
            valid_s1_reg <= pxlValid;
            sof_s1_reg   <= startOfFrame;
        end
    end

    // Scanning from the lowest priority upward leaves the lowest hitting index selected.
    always_comb begin
        tmp_rgb_next = bg_s1_reg;
        win_next     = WIN_BG;
        for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
            if (hit_s1_reg[i]) begin
                tmp_rgb_next = rgb_s1_reg[8*i +: 8];
                win_next     = 5'(i);
            end
        end
        if (!valid_s1_reg) begin
            tmp_rgb_next = 8'h00;
            win_next     = WIN_BLANK;
        end
        collision_next = (hit_s1_reg[COLLIDER_LAYER] && valid_s1_reg) ?
                         (hit_s1_reg & ~COLLIDER_MASK) : '0;
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            tmp_rgb_reg     <= '0;
            win_reg         <= WIN_BLANK;
            valid_s2_reg    <= 1'b0;
            collision_reg   <= '0;
            acc_reg         <= '0;
            frame_coll_reg  <= '0;
            frame_valid_reg <= 1'b0;
        end else begin
            tmp_rgb_reg   <= tmp_rgb_next;
            win_reg       <= win_next;
            valid_s2_reg  <= valid_s1_reg;
            collision_reg <= collision_next;
            // The start-of-frame pixel opens the new accumulation rather than closing the old one.
            if (sof_s1_reg) begin
                frame_coll_reg  <= acc_reg;
                frame_valid_reg <= 1'b1;
                acc_reg         <= collision_next;
            end else begin
                frame_valid_reg <= 1'b0;
                acc_reg         <= acc_reg | collision_next;
            end
        end
    end

    assign redOut              = {tmp_rgb_reg[7:5], {5{tmp_rgb_reg[5]}}};
    assign greenOut            = {tmp_rgb_reg[4:2], {5{tmp_rgb_reg[2]}}};
    assign blueOut             = {tmp_rgb_reg[1:0], {6{tmp_rgb_reg[0]}}};
    assign pxlValidOut         = valid_s2_reg;
    assign winLayer            = win_reg;
    assign collisionNow        = collision_reg;
    assign frameCollision      = frame_coll_reg;
    assign frameCollisionValid = frame_valid_reg;

endmodule

// File: tb/tb_layer_compositor.sv
// Directed bench for layer_compositor (NUM_LAYERS=10, key 8'hFF, collider layer 0).
module tb_layer_compositor;

    logic        clk = 1'b0;
    logic        resetN;
    logic [9:0]  layerEnable;
    logic [9:0]  drawReq;
    logic [79:0] layerRGB;
    logic [7:0]  backGroundRGB;
    logic        pxlValid;
    logic        startOfFrame;
    logic [7:0]  redOut, greenOut, blueOut;
    logic        pxlValidOut;
    logic [4:0]  winLayer;
    logic [9:0]  collisionNow;
    logic [9:0]  frameCollision;
    logic        frameCollisionValid;

    int vectors     = 0;
    int miscompares = 0;

    layer_compositor #(
        .NUM_LAYERS(10), .TRANSPARENT_KEY(8'hFF), .KEY_EN(1'b1), .COLLIDER_LAYER(0)
    ) dut (
        .clk(clk), .resetN(resetN),
        .layerEnable(layerEnable), .drawReq(drawReq), .layerRGB(layerRGB),
        .backGroundRGB(backGroundRGB), .pxlValid(pxlValid), .startOfFrame(startOfFrame),
        .redOut(redOut), .greenOut(greenOut), .blueOut(blueOut),
        .pxlValidOut(pxlValidOut), .winLayer(winLayer),
        .collisionNow(collisionNow), .frameCollision(frameCollision),
        .frameCollisionValid(frameCollisionValid)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        $display("vec %0d %s: observed %0h expected %0h", vectors, tag, obs, exp);
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        resetN        = 1'b1;
        layerEnable   = 10'h3FF;
        drawReq       = '0;
        layerRGB      = '0;
        backGroundRGB = 8'h00;
        pxlValid      = 1'b0;
        startOfFrame  = 1'b0;

        // Asynchronous reset before any clock edge
        #1 resetN = 1'b0;
        #1;
        chk("rst_win",   32'(winLayer), 32'd31);
        chk("rst_rgb",   {8'h0, redOut, greenOut, blueOut}, 32'h0);
        chk("rst_vout",  32'(pxlValidOut), 32'd0);
        chk("rst_coll",  32'(collisionNow), 32'd0);
        chk("rst_fc",    32'(frameCollision), 32'd0);
        chk("rst_fcv",   32'(frameCollisionValid), 32'd0);
        tick();
        tick();
        #3 resetN = 1'b1;
        tick();
        tick();

        // Priority: layers 2 and 5 hit, layer 2 wins
        pxlValid = 1'b1;
        drawReq  = 10'b00_0010_0100;
        layerRGB[8*2 +: 8] = 8'hE0;
        layerRGB[8*5 +: 8] = 8'h1C;
        tick();
        chk("lat_win", 32'(winLayer), 32'd31);
        tick();
        chk("pri_win",  32'(winLayer), 32'd2);
        chk("pri_rgb",  {8'h0, redOut, greenOut, blueOut}, 32'h00FF0000);
        chk("pri_vout", 32'(pxlValidOut), 32'd1);
        chk("pri_coll", 32'(collisionNow), 32'd0);

        // Colour key makes layer 2 transparent
        layerRGB[8*2 +: 8] = 8'hFF;
        tick();
        tick();
        chk("key_win", 32'(winLayer), 32'd5);
        chk("key_rgb", {8'h0, redOut, greenOut, blueOut}, 32'h0000FF00);

        // Disable layer 5: background shows
        layerEnable[5] = 1'b0;
        backGroundRGB  = 8'h03;
        tick();
        tick();
        chk("bg_win", 32'(winLayer), 32'd10);
        chk("bg_rgb", {8'h0, redOut, greenOut, blueOut}, 32'h000000FF);

        // Blanking with collider and layer 3 drawing
        layerEnable = 10'h3FF;
        layerRGB[8*2 +: 8] = 8'hE0;
        drawReq  = 10'b00_0000_1001;
        pxlValid = 1'b0;
        tick();
        tick();
        chk("blk_win",  32'(winLayer), 32'd31);
        chk("blk_rgb",  {8'h0, redOut, greenOut, blueOut}, 32'h0);
        chk("blk_coll", 32'(collisionNow), 32'd0);
        chk("blk_vout", 32'(pxlValidOut), 32'd0);

        // Frame accumulation, streamed one pixel per clock
        layerRGB[8*0 +: 8] = 8'h1C;
        pxlValid = 1'b1;
        startOfFrame = 1'b1; drawReq = 10'h000; tick();            // P0
        startOfFrame = 1'b0; drawReq = 10'h009; tick();            // P1
        chk("f0_fcv", 32'(frameCollisionValid), 32'd1);
        chk("f0_fc",  32'(frameCollision), 32'd0);
        drawReq = 10'h081; tick();                                  // P2
        chk("p1_coll", 32'(collisionNow), 32'h008);
        chk("p1_fcv",  32'(frameCollisionValid), 32'd0);
        drawReq = 10'h008; tick();                                  // P3
        chk("p2_coll", 32'(collisionNow), 32'h080);
        startOfFrame = 1'b1; drawReq = 10'h000; tick();            // P4
        chk("p3_coll", 32'(collisionNow), 32'h000);
        startOfFrame = 1'b0; tick();                                // P5
        chk("fA_fcv", 32'(frameCollisionValid), 32'd1);
        chk("fA_fc",  32'(frameCollision), 32'h088);
        tick();                                                     // P6
        chk("fA_pulse", 32'(frameCollisionValid), 32'd0);
        chk("fA_hold",  32'(frameCollision), 32'h088);

        // Overlap on the start-of-frame pixel belongs to the new frame
        startOfFrame = 1'b1; drawReq = 10'h011; tick();            // P7
        startOfFrame = 1'b0; drawReq = 10'h000; tick();            // P8
        chk("fB_fcv",  32'(frameCollisionValid), 32'd1);
        chk("fB_fc",   32'(frameCollision), 32'h000);
        chk("p7_coll", 32'(collisionNow), 32'h010);

        // Back-to-back start-of-frame pulses
        startOfFrame = 1'b1; drawReq = 10'h041; tick();            // P9
        startOfFrame = 1'b1; drawReq = 10'h000; tick();            // P10
        chk("fC_fcv",  32'(frameCollisionValid), 32'd1);
        chk("fC_fc",   32'(frameCollision), 32'h010);
        chk("p9_coll", 32'(collisionNow), 32'h040);
        startOfFrame = 1'b0; tick();                                // P11
        chk("fD_fcv", 32'(frameCollisionValid), 32'd1);
        chk("fD_fc",  32'(frameCollision), 32'h040);

        // Reset mid-frame discards the accumulator
        drawReq = 10'h201; tick();
        drawReq = 10'h000; tick();
        chk("pre_coll", 32'(collisionNow), 32'h200);
        chk("pre_win",  32'(winLayer), 32'd0);
        #2 resetN = 1'b0;
        #1;
        chk("mrst_win",  32'(winLayer), 32'd31);
        chk("mrst_rgb",  {8'h0, redOut, greenOut, blueOut}, 32'h0);
        chk("mrst_coll", 32'(collisionNow), 32'd0);
        chk("mrst_vout", 32'(pxlValidOut), 32'd0);
        #2 resetN = 1'b1;
        tick();
        startOfFrame = 1'b1; tick();
        startOfFrame = 1'b0; tick();
        chk("fE_fcv", 32'(frameCollisionValid), 32'd1);
        chk("fE_fc",  32'(frameCollision), 32'h000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
